// File: rtl/store_merge_unit.sv
// store_merge_unit
//   Store path between EX and the data memory port. sw writes the store word
//   directly; sb reads the addressed word, merges Din[7:0] into byte lane
//   Addr[1:0] (little-endian), and writes the merged word back. Memory reads
//   and writes use req/ack handshakes with a bounded wait (TMO_CYC).
//
//   Optional feature macro: STORE_ALIGN_CHECK_EN
//     defined   - sw with Addr[1:0]!=0 skips memory and ends with Done+Err.
//     undefined - Addr[1:0] ignored for sw; Err only on timeout.
//
// Ports
//   Clk, Rst_n                 clock, async active-low reset
//   Start, Sel, Addr, Din      request (Sel=1 sw, Sel=0 sb); taken only in IDLE
//   Busy, Done, Err            status; Done/Err are single-cycle pulses
//   Mem_Addr                   word-aligned memory address
//   Mem_Rd_En / Mem_Rdata / Mem_Rd_Valid   read channel
//   Mem_Wr_En / Mem_Wdata / Mem_Wr_Ack     write channel
module store_merge_unit #(
  parameter int ADDR_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic              Sel,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       Din,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_Rd_En,
  input  logic [31:0]       Mem_Rdata,
  input  logic              Mem_Rd_Valid,
  output logic              Mem_Wr_En,
  output logic [31:0]       Mem_Wdata,
  input  logic              Mem_Wr_Ack
);

  localparam int CNT_W = $clog2(TMO_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  // Only the sb merge needs anything beyond Mem_Addr/Mem_Wdata after accept.
  typedef struct packed {
    logic [1:0] lane;
    logic [7:0] sb_data;
  } req_t;

  state_t           state, state_nxt;
  req_t             req;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             err_q;
  logic             misalign;
  logic [31:0]      merged;

  // Last permitted wait cycle: no valid/ack here means abort.
  assign tmo_hit = (tmo_cnt == CNT_W'(TMO_CYC - 1));

`ifdef STORE_ALIGN_CHECK_EN
  assign misalign = Sel && (Addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    merged = Mem_Rdata;
    case (req.lane)
      2'd0: merged[7:0]   = req.sb_data;
      2'd1: merged[15:8]  = req.sb_data;
      2'd2: merged[23:16] = req.sb_data;
      2'd3: merged[31:24] = req.sb_data;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (Start) begin
        if (misalign) state_nxt = S_DONE;
        else          state_nxt = Sel ? S_WR : S_RD;
      end
      S_RD:   if (Mem_Rd_Valid || tmo_hit) state_nxt = Mem_Rd_Valid ? S_WR : S_DONE;
      S_WR:   if (Mem_Wr_Ack || tmo_hit)   state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      req       <= '0;
      Mem_Addr  <= '0;
      Mem_Wdata <= '0;
      tmo_cnt   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (Start) begin
          req.lane    <= Addr[1:0];
          req.sb_data <= Din[7:0];
          Mem_Addr    <= {Addr[ADDR_W-1:2], 2'b00};
          Mem_Wdata   <= Din;
          err_q       <= misalign;
          tmo_cnt     <= '0;
        end
        S_RD: begin
          if (Mem_Rd_Valid) begin
            Mem_Wdata <= merged;
            tmo_cnt   <= '0;  // fresh wait budget for the write phase
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        S_WR: begin
          if (!Mem_Wr_Ack) begin
            if (tmo_hit) err_q <= 1'b1;
            else         tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          err_q   <= 1'b0;
          tmo_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Handshake requests and status decode straight from state so that a
  // reset drops them immediately and no input path feeds an output.
  assign Mem_Rd_En = (state == S_RD);
  assign Mem_Wr_En = (state == S_WR);
  assign Busy      = (state == S_RD) || (state == S_WR);
  assign Done      = (state == S_DONE);
  assign Err       = (state == S_DONE) && err_q;

endmodule

// File: tb/tb_store_merge_unit.sv
module tb_store_merge_unit;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Start, Sel;
  logic [31:0] Addr, Din;
  logic        Busy, Done, Err;
  logic [31:0] Mem_Addr;
  logic        Mem_Rd_En, Mem_Rd_Valid, Mem_Wr_En, Mem_Wr_Ack;
  logic [31:0] Mem_Rdata, Mem_Wdata;

  int n_cmp = 0;
  int n_err = 0;

  store_merge_unit #(.ADDR_W(32), .TMO_CYC(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Sel(Sel), .Addr(Addr), .Din(Din),
    .Busy(Busy), .Done(Done), .Err(Err), .Mem_Addr(Mem_Addr),
    .Mem_Rd_En(Mem_Rd_En), .Mem_Rdata(Mem_Rdata), .Mem_Rd_Valid(Mem_Rd_Valid),
    .Mem_Wr_En(Mem_Wr_En), .Mem_Wdata(Mem_Wdata), .Mem_Wr_Ack(Mem_Wr_Ack)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change at negedge; outputs are sampled there too (mid-cycle).
  task automatic go(input logic s, input logic [31:0] a, input logic [31:0] d);
    Start = 1'b1; Sel = s; Addr = a; Din = d;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  Busy,      0);
    chk({tag, "_done"},  Done,      0);
    chk({tag, "_err"},   Err,       0);
    chk({tag, "_rden"},  Mem_Rd_En, 0);
    chk({tag, "_wren"},  Mem_Wr_En, 0);
  endtask

  initial begin
    Rst_n = 1'b0; Start = 0; Sel = 0; Addr = 0; Din = 0;
    Mem_Rdata = 0; Mem_Rd_Valid = 0; Mem_Wr_Ack = 0;
    #1;
    chk_idle("rst");
    chk("rst_addr",  Mem_Addr,  0);
    chk("rst_wdata", Mem_Wdata, 0);
    @(negedge Clk); @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    // 1: sw, immediate ack
    Mem_Wr_Ack = 1'b1;
    go(1, 32'h100, 32'hDEADBEEF);
    @(negedge Clk); Start = 0;
    chk("t1_wren",  Mem_Wr_En, 1);
    chk("t1_rden",  Mem_Rd_En, 0);
    chk("t1_addr",  Mem_Addr,  32'h100);
    chk("t1_wdata", Mem_Wdata, 32'hDEADBEEF);
    chk("t1_busy",  Busy,      1);
    chk("t1_done0", Done,      0);
    @(negedge Clk);
    chk("t1_done",  Done,      1);
    chk("t1_err",   Err,       0);
    chk("t1_busy0", Busy,      0);
    chk("t1_rden2", Mem_Rd_En, 0);
    @(negedge Clk);
    chk_idle("t1_end");

    // 2: sb lane 3 then lane 1, zero-wait memory
    Mem_Rdata = 32'h11223344; Mem_Rd_Valid = 1'b1;
    go(0, 32'h203, 32'h000000A5);
    @(negedge Clk); Start = 0;
    chk("t2_rden",  Mem_Rd_En, 1);
    chk("t2_wren0", Mem_Wr_En, 0);
    chk("t2_addr",  Mem_Addr,  32'h200);
    @(negedge Clk);
    chk("t2_wren",  Mem_Wr_En, 1);
    chk("t2_wdata", Mem_Wdata, 32'hA5223344);
    @(negedge Clk);
    chk("t2_done",  Done,      1);
    @(negedge Clk);
    go(0, 32'h201, 32'h000000A5);
    @(negedge Clk); Start = 0;
    chk("t2b_addr", Mem_Addr,  32'h200);
    @(negedge Clk);
    chk("t2b_wdata", Mem_Wdata, 32'h1122A544);
    @(negedge Clk);
    chk("t2b_done", Done,      1);
    @(negedge Clk);
    Mem_Rd_Valid = 0; Mem_Wr_Ack = 0;

    // 3: sb lane 2, read valid after 3 wait cycles, ack after 2; stray Starts
    Mem_Rdata = 32'hAABBCCDD;
    go(0, 32'h002, 32'h0000005A);
    for (int k = 1; k <= 9; k++) begin
      @(negedge Clk);
      Start = (k == 2 || k == 6 || k == 8);
      Sel = 1'b1; Addr = 32'h300; Din = 32'hFFFFFFFF;
      Mem_Rd_Valid = (k == 4);
      Mem_Wr_Ack   = (k == 7);
      chk($sformatf("t3_rden_%0d", k), Mem_Rd_En, (k <= 4) ? 1 : 0);
      chk($sformatf("t3_wren_%0d", k), Mem_Wr_En, (k >= 5 && k <= 7) ? 1 : 0);
      chk($sformatf("t3_done_%0d", k), Done,      (k == 8) ? 1 : 0);
      chk($sformatf("t3_busy_%0d", k), Busy,      (k <= 7) ? 1 : 0);
      chk($sformatf("t3_err_%0d", k),  Err,       0);
      if (k <= 8) chk($sformatf("t3_addr_%0d", k), Mem_Addr, 32'h000);
      if (k >= 5 && k <= 7) chk($sformatf("t3_wdata_%0d", k), Mem_Wdata, 32'hAA5ACCDD);
    end
    Start = 0; Mem_Rd_Valid = 0; Mem_Wr_Ack = 0;
    @(negedge Clk);

    // 4: write ack never comes, TMO_CYC=4
    go(1, 32'h040, 32'h12345678);
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk); Start = 0;
      chk($sformatf("t4_wren_%0d", k), Mem_Wr_En, (k <= 4) ? 1 : 0);
      chk($sformatf("t4_done_%0d", k), Done,      (k == 5) ? 1 : 0);
      chk($sformatf("t4_err_%0d", k),  Err,       (k == 5) ? 1 : 0);
    end
    Mem_Wr_Ack = 1'b1;
    go(1, 32'h044, 32'h87654321);
    @(negedge Clk); Start = 0;
    chk("t4b_wren",  Mem_Wr_En, 1);
    chk("t4b_addr",  Mem_Addr,  32'h044);
    @(negedge Clk);
    chk("t4b_done",  Done,      1);
    chk("t4b_err",   Err,       0);
    @(negedge Clk);
    Mem_Wr_Ack = 0;

    // 5: async reset while in RD
    go(0, 32'h081, 32'h00000077);
    @(negedge Clk); Start = 0;
    chk("t5_rden", Mem_Rd_En, 1);
    #2 Rst_n = 1'b0;
    #1;
    chk_idle("t5_rst");
    chk("t5_addr",  Mem_Addr,  0);
    chk("t5_wdata", Mem_Wdata, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk($sformatf("t5_nodone_%0d", k), Done, 0);
    end
    Rst_n = 1'b1;
    @(negedge Clk);
    chk_idle("t5_post");
    Mem_Wr_Ack = 1'b1;
    go(1, 32'h080, 32'h0BADF00D);
    @(negedge Clk); Start = 0;
    chk("t5b_wdata", Mem_Wdata, 32'h0BADF00D);
    @(negedge Clk);
    chk("t5b_done",  Done,      1);
    chk("t5b_err",   Err,       0);
    @(negedge Clk);

    // 6: misaligned sw
    go(1, 32'h102, 32'hCAFEF00D);
    @(negedge Clk); Start = 0;
`ifdef STORE_ALIGN_CHECK_EN
    chk("t6_done", Done,      1);
    chk("t6_err",  Err,       1);
    chk("t6_wren", Mem_Wr_En, 0);
    @(negedge Clk);
    chk("t6_wren2", Mem_Wr_En, 0);
`else
    chk("t6_wren", Mem_Wr_En, 1);
    chk("t6_addr", Mem_Addr,  32'h100);
    chk("t6_wdata", Mem_Wdata, 32'hCAFEF00D);
    @(negedge Clk);
    chk("t6_done", Done,      1);
    chk("t6_err",  Err,       0);
`endif
    @(negedge Clk);
    Mem_Wr_Ack = 0;
    chk_idle("t6_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
